// File: rtl/rc5_keysched_ctrl.sv
// RC5 key-schedule sequencer: runs the L-load and S-init engines together,
// then the mix engine, and arbitrates the single-port L RAM between them.
module rc5_keysched_ctrl #(
   parameter  int B       = 16,
   parameter  int W       = 32,
   parameter  int R       = 12,
   parameter  int TIMEOUT = 1024,
   localparam int U       = W / 8,
   localparam int C       = B / U,
   localparam int CL      = $clog2(C)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iStart,
   input  logic          iAbort,
   output logic          oBusy,
   output logic          oReady,
   output logic          oError,
   output logic [15:0]   oCycles,
   output logic          oLStart,
   input  logic          iLDone,
   input  logic [CL-1:0] iL_addr,
   input  logic          iL_we,
   input  logic [W-1:0]  iL_wdata,
   output logic          oSStart,
   input  logic          iSDone,
   output logic          oMStart,
   input  logic          iMDone,
   input  logic [CL-1:0] iM_addr,
   input  logic          iM_we,
   input  logic [W-1:0]  iM_wdata,
   output logic [CL-1:0] oL_addr,
   output logic          oL_we,
   output logic [W-1:0]  oL_wdata
);

   localparam int WDW = $clog2(TIMEOUT) + 1;

   // R only sizes the S table inside the engines; it is carried here so the
   // whole key-schedule parameter set is overridden in one place.
   if (R > 0) begin : g_rounds
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MIX,
      S_READY,
      S_ERROR
   } state_t;

   state_t           state, state_nxt;
   logic             start_q;
   logic             start_edge;
   logic             l_f, s_f;
   logic             l_ok, s_ok;
   logic             wd_exp;
   logic             enter_load;
   logic [WDW-1:0]   wd_cnt;
   logic [15:0]      cyc_cnt;

   // Next-state decode; abort has top priority, a done beats the watchdog.
   always_comb begin
      start_edge = iStart & ~start_q;
      l_ok       = l_f | iLDone;
      s_ok       = s_f | iSDone;
      wd_exp     = (wd_cnt == WDW'(TIMEOUT - 1));
      state_nxt  = state;
      if (iAbort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start_edge) state_nxt = S_LOAD;
            S_LOAD:  begin
               if (l_ok && s_ok)   state_nxt = S_MIX;
               else if (wd_exp)    state_nxt = S_ERROR;
            end
            S_MIX:   begin
               if (iMDone)         state_nxt = S_MIX == S_MIX ? S_READY : S_MIX;
               else if (wd_exp)    state_nxt = S_ERROR;
            end
            S_READY: if (start_edge) state_nxt = S_LOAD;
            S_ERROR: if (start_edge) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
         endcase
      end
      enter_load = (state_nxt == S_LOAD) && (state != S_LOAD);
   end

   // State register and start-edge history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         start_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         start_q <= iStart;
      end
   end

   // Sticky done flags for the parallel LOAD engines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_f <= 1'b0;
         s_f <= 1'b0;
      end else if (enter_load) begin
         l_f <= 1'b0;
         s_f <= 1'b0;
      end else if (state == S_LOAD) begin
         l_f <= l_ok;
         s_f <= s_ok;
      end
   end

   // Per-phase watchdog and saturating run-length counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt  <= '0;
         cyc_cnt <= '0;
         oCycles <= '0;
      end else begin
         if (state_nxt != state)
            wd_cnt <= '0;
         else if (state == S_LOAD || state == S_MIX)
            wd_cnt <= wd_cnt + WDW'(1);

         if (enter_load)
            cyc_cnt <= '0;
         else if ((state == S_LOAD || state == S_MIX) && cyc_cnt != '1)
            cyc_cnt <= cyc_cnt + 16'd1;

         if (state == S_MIX && state_nxt == S_READY)
            oCycles <= cyc_cnt;
      end
   end

   // Registered status and engine enables, decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oBusy   <= 1'b0;
         oLStart <= 1'b0;
         oSStart <= 1'b0;
         oMStart <= 1'b0;
         oReady  <= 1'b0;
         oError  <= 1'b0;
      end else begin
         oBusy   <= (state_nxt == S_LOAD) || (state_nxt == S_MIX);
         oLStart <= (state_nxt == S_LOAD);
         oSStart <= (state_nxt == S_LOAD);
         oMStart <= (state_nxt == S_MIX);
         oReady  <= (state_nxt == S_READY);
         oError  <= (state_nxt == S_ERROR);
      end
   end

   // L RAM port goes to the engine owning the current phase, idle otherwise.
   always_comb begin
      oL_addr  = '0;
      oL_we    = 1'b0;
      oL_wdata = '0;
      case (state)
         S_LOAD: begin
            oL_addr  = iL_addr;
            oL_we    = iL_we;
            oL_wdata = iL_wdata;
         end
         S_MIX: begin
            oL_addr  = iM_addr;
            oL_we    = iM_we;
            oL_wdata = iM_wdata;
         end
         default: ;
      endcase
   end

endmodule
